// File: rtl/bitserial_seq.sv
// -----------------------------------------------------------------------------
// bitserial_seq
// Parallel-side driver/collector for a 1-bit serial ALU. On start it latches
// an opcode and two operands. It then presents the operands to the ALU one bit
// per cycle, LSB first. The registered ALU output comes back one cycle later
// and is gathered into a parallel result.
//
// State table:
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start; ALU held in clear (ser_rstn=0)
//   S_SHIFT | driving operand bit k; sampling ALU bit k-1 (k>=1)
//   S_DRAIN | one extra cycle to collect the last ALU bit
//   S_DONE  | one-cycle done pulse; ALU cleared again before the next op
//
// Ports:
//   clk, rstn           clock; asynchronous active-low reset
//   start, op, opa, opb operation request, sampled/latched in S_IDLE only
//   busy, done, result  status and collected parallel result
//   ser_op, ser_a/b     opcode and serial operand bits to the ALU
//   ser_rstn            synchronous clear for the ALU out/carry registers
//   ser_out             registered ALU result bit (one-cycle latency)
// -----------------------------------------------------------------------------
module bitserial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       ser_op,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_rstn,
    input  logic             ser_out
);

    localparam int KW = $clog2(WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             armed_q;
    logic             busy_d, done_d, ser_a_d, ser_b_d, ser_rstn_d;
    logic [3:0]       ser_op_d;
    logic [WIDTH-1:0] result_d;

    // Every output is registered. The comb block computes the value each
    // output takes in the next state.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        ser_op_d   = ser_op;
        result_d   = result;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        ser_a_d    = 1'b0;
        ser_b_d    = 1'b0;
        ser_rstn_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // armed_q guarantees one IDLE cycle after reset release
                if (start && armed_q) begin
                    state_d    = S_SHIFT;
                    k_d        = '0;
                    opa_d      = opa;
                    opb_d      = opb;
                    ser_op_d   = op;
                    busy_d     = 1'b1;
                    ser_rstn_d = 1'b1;
                    ser_a_d    = opa[0];
                    ser_b_d    = opb[0];
                end
            end
            S_SHIFT: begin
                busy_d     = 1'b1;
                ser_rstn_d = 1'b1;
                // ser_out now carries the ALU's answer for bit k-1
                if (k_q != '0)
                    result_d[k_q - KW'(1)] = ser_out;
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d     = k_q + KW'(1);
                    ser_a_d = opa_q[k_d];
                    ser_b_d = opb_q[k_d];
                end
            end
            S_DRAIN: begin
                result_d[WIDTH-1] = ser_out;
                state_d           = S_DONE;
                done_d            = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                k_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            armed_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            ser_op   <= 4'd0;
            ser_a    <= 1'b0;
            ser_b    <= 1'b0;
            ser_rstn <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            armed_q  <= 1'b1;
            busy     <= busy_d;
            done     <= done_d;
            result   <= result_d;
            ser_op   <= ser_op_d;
            ser_a    <= ser_a_d;
            ser_b    <= ser_b_d;
            ser_rstn <= ser_rstn_d;
        end
    end

endmodule
